writeback_register_file: RTL and testbench
==========================================

Name: writeback_register_file

Overview:
- Write-back end of the EX/WB pipeline interface. Consumes the registered write enable, ALU result and destination address, and commits them to a 32-entry architectural register file.
- Serves two asynchronous read ports to decode, with write-first bypass.
- Keeps a per-register pending-write scoreboard. Decode issue marks a register busy; write-back releases it. The block raises a stall when decode reads or targets a register that cannot be used yet.

Parameters:
- XLEN, 32, data width of registers and write-back data
- NREG, 32, number of architectural registers (address width = 5)
- CNT_W, 2, width of per-register pending counter (max outstanding writes = 2^CNT_W-1 = 3)

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- reg_write_en_wb_in  input  1  write enable from EX/WB pipeline register
- alu_out_wb_in  input  XLEN  write-back data from EX/WB pipeline register
- register_addr_wb_in  input  5  destination register from EX/WB pipeline register
- rs1_addr  input  5  read port 1 address
- rs2_addr  input  5  read port 2 address
- rs1_used  input  1  decode instruction actually reads rs1
- rs2_used  input  1  decode instruction actually reads rs2
- rs1_data  output  XLEN  read port 1 data, combinational
- rs2_data  output  XLEN  read port 2 data, combinational
- issue_valid  input  1  decode presents an instruction this cycle
- issue_we  input  1  presented instruction writes a register
- issue_rd  input  5  presented instruction destination
- issue_stall  output  1  decode must hold; instruction not accepted
- issue_accept  output  1  instruction accepted this cycle

Behaviour:
Register file
- rst: all NREG registers cleared to 0; all pending counters cleared to 0.
- Write: on a clk edge with reg_write_en_wb_in=1 and register_addr_wb_in!=0, reg[addr] <= alu_out_wb_in.
- Writes to x0 are discarded. x0 always reads 0.
- Read: rsN_data = 0 if rsN_addr=0.
  - Else alu_out_wb_in if reg_write_en_wb_in=1 and register_addr_wb_in=rsN_addr (write-first bypass, same cycle).
  - Else reg[rsN_addr].
- Read is combinational: 0-cycle latency. A write becomes architecturally visible the cycle after its edge, and is bypassed in its own cycle.

Scoreboard
- wb_rel[r] = reg_write_en_wb_in && register_addr_wb_in==r && r!=0.
- eff[r] = pend[r] - wb_rel[r], the count after this cycle's release.
- Source hazard: rsN_used && rsN_addr!=0 && eff[rsN_addr]!=0.
- Destination saturation: issue_we && issue_rd!=0 && pend[issue_rd]==2^CNT_W-1 && !wb_rel[issue_rd].
- issue_stall = issue_valid && (source hazard on rs1 or rs2 || destination saturation). Combinational.
- issue_accept = issue_valid && !issue_stall.
- Counter update per register r, on each clk edge:
  - inc = issue_accept && issue_we && issue_rd==r && r!=0.
  - pend[r] <= pend[r] + inc - wb_rel[r].
  - Simultaneous inc and release on the same r leaves it unchanged.
- Write-back with pend[r]=0 (unscoreboarded write) is legal: data is written, counter holds at 0 (no underflow).
- x0 is never scoreboarded; pend[0] stays 0.
- rst mid-operation: all counters and registers return to 0 on the next edge regardless of concurrent issue or write-back. issue_stall/issue_accept then follow inputs combinationally.

Decomposition:
- Shared package riscv_pkg:
  - XLEN, NREG, REG_ADDR_W=5
  - REG_ZERO=5'd0 constant
  - reg_addr_t typedef
- One natural sub-module: pending_scoreboard, holding the NREG counters and the stall/accept logic. The top holds storage and bypass muxes.

Test Plan:
- Reset then read all: assert rst one cycle; rs1_addr=5, rs2_addr=31 -> rs1_data=0, rs2_data=0, issue_stall=0.
- Write and bypass: wb_en=1, addr=3, data=0xDEADBEEF, rs1_addr=3 -> rs1_data=0xDEADBEEF same cycle. Next cycle wb_en=0 -> still 0xDEADBEEF.
- x0 protection: wb_en=1, addr=0, data=0x12345678 -> reads of x0 give 0 in that cycle and after.
- RAW stall: issue x5 write (accepted); next cycle rs1_addr=5, rs1_used=1 -> issue_stall=1. Then wb_en=1, addr=5, data=0x42 -> stall drops same cycle, rs1_data=0x42, issue_accept=1.
- Saturation: three accepted issues to x7 with no write-back; fourth issue to x7 -> issue_stall=1. With wb_en=1 to x7 in that cycle -> accepted, count stays 3.
- Simultaneous issue and release: pend[9]=1, accepted issue to x9 plus wb to x9 in the same cycle -> pend[9] remains 1. Subsequent read of x9 stalls until the next wb to x9.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared register-file widths, register address type and scoreboard counter limits
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int REG_ADDR_W = 5;
  localparam int CNT_W = 2;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  localparam reg_addr_t REG_ZERO = 5'd0;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
endpackage

// File: rtl/pending_scoreboard.sv
// pending_scoreboard: per-register pending-write counters; wb_* release, issue_* claim, rs*/issue_* drive combinational issue_stall/issue_accept
module pending_scoreboard
  import riscv_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      wb_en,
  input  reg_addr_t wb_addr,
  input  reg_addr_t rs1_addr,
  input  reg_addr_t rs2_addr,
  input  logic      rs1_used,
  input  logic      rs2_used,
  input  logic      issue_valid,
  input  logic      issue_we,
  input  reg_addr_t issue_rd,
  output logic      issue_stall,
  output logic      issue_accept
);
  logic [CNT_W-1:0] pend [NREG];
  logic [NREG-1:0] rel;
  logic [NREG-1:0] inc;
  logic haz1;
  logic haz2;
  logic sat;
  always_comb begin
    rel = '0;
    inc = '0;
    if (wb_en && wb_addr != REG_ZERO) rel[wb_addr] = 1'b1;
    if (issue_accept && issue_we && issue_rd != REG_ZERO) inc[issue_rd] = 1'b1;
  end
  // a register stays hazardous only if something is still outstanding after this cycle's release
  assign haz1 = rs1_used && rs1_addr != REG_ZERO && pend[rs1_addr] > CNT_W'(rel[rs1_addr]);
  assign haz2 = rs2_used && rs2_addr != REG_ZERO && pend[rs2_addr] > CNT_W'(rel[rs2_addr]);
  assign sat = issue_we && issue_rd != REG_ZERO && pend[issue_rd] == CNT_MAX && !rel[issue_rd];
  assign issue_stall = issue_valid && (haz1 || haz2 || sat);
  assign issue_accept = issue_valid && !issue_stall;
  // release of an idle counter holds at zero: unscoreboarded write-back
  always_ff @(posedge clk)
    for (int r = 0; r < NREG; r++)
      pend[r] <= rst ? '0
               : inc[r] == rel[r] ? pend[r]
               : inc[r] ? pend[r] + CNT_W'(1)
               : pend[r] == '0 ? pend[r]
               : pend[r] - CNT_W'(1);
endmodule

// File: rtl/writeback_register_file.sv
// writeback_register_file: 32-entry register file with write-back port (*_wb_in), two bypassed async read ports (rs*), and scoreboarded issue handshake (issue_*)
module writeback_register_file
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            reg_write_en_wb_in,
  input  logic [XLEN-1:0] alu_out_wb_in,
  input  logic [4:0]      register_addr_wb_in,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  input  logic            rs1_used,
  input  logic            rs2_used,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            issue_valid,
  input  logic            issue_we,
  input  logic [4:0]      issue_rd,
  output logic            issue_stall,
  output logic            issue_accept
);
  logic [XLEN-1:0] regs [NREG];
  logic wr;
  assign wr = reg_write_en_wb_in && register_addr_wb_in != REG_ZERO;
  always_ff @(posedge clk)
    if (rst)
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
    else if (wr)
      regs[register_addr_wb_in] <= alu_out_wb_in;
  assign rs1_data = rs1_addr == REG_ZERO ? '0
                  : reg_write_en_wb_in && register_addr_wb_in == rs1_addr ? alu_out_wb_in
                  : regs[rs1_addr];
  assign rs2_data = rs2_addr == REG_ZERO ? '0
                  : reg_write_en_wb_in && register_addr_wb_in == rs2_addr ? alu_out_wb_in
                  : regs[rs2_addr];
  pending_scoreboard u_sb (
    .clk          (clk),
    .rst          (rst),
    .wb_en        (reg_write_en_wb_in),
    .wb_addr      (register_addr_wb_in),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rs1_used     (rs1_used),
    .rs2_used     (rs2_used),
    .issue_valid  (issue_valid),
    .issue_we     (issue_we),
    .issue_rd     (issue_rd),
    .issue_stall  (issue_stall),
    .issue_accept (issue_accept)
  );
endmodule

// File: tb/tb_writeback_register_file.sv
// tb_writeback_register_file: directed plan plus random traffic checked against an integer reference model
module tb_writeback_register_file;
  logic clk = 0;
  logic rst;
  logic wb_en;
  logic [31:0] wb_data;
  logic [4:0] wb_addr;
  logic [4:0] rs1_addr;
  logic [4:0] rs2_addr;
  logic rs1_used;
  logic rs2_used;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic issue_valid;
  logic issue_we;
  logic [4:0] issue_rd;
  logic issue_stall;
  logic issue_accept;
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] m_reg [32];
  int m_pend [32];
  logic [31:0] o_rs1;
  logic o_stall;
  logic o_accept;

  always #5 clk = ~clk;

  writeback_register_file dut (
    .clk                 (clk),
    .rst                 (rst),
    .reg_write_en_wb_in  (wb_en),
    .alu_out_wb_in       (wb_data),
    .register_addr_wb_in (wb_addr),
    .rs1_addr            (rs1_addr),
    .rs2_addr            (rs2_addr),
    .rs1_used            (rs1_used),
    .rs2_used            (rs2_used),
    .rs1_data            (rs1_data),
    .rs2_data            (rs2_data),
    .issue_valid         (issue_valid),
    .issue_we            (issue_we),
    .issue_rd            (issue_rd),
    .issue_stall         (issue_stall),
    .issue_accept        (issue_accept)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int released(input int r);
    return (wb_en && wb_addr == r && r != 0) ? 1 : 0;
  endfunction

  function automatic logic [31:0] read_model(input int a);
    if (a == 0) return 0;
    if (wb_en && wb_addr == a) return wb_data;
    return m_reg[a];
  endfunction

  function automatic bit busy(input bit used, input int a);
    int left;
    left = m_pend[a] - released(a);
    return used && a != 0 && left > 0;
  endfunction

  task automatic drive(input bit r, input bit we, input int wa, input logic [31:0] d,
                       input int a1, input int a2, input bit u1, input bit u2,
                       input bit iv, input bit iwe, input int ird);
    @(negedge clk);
    rst = r; wb_en = we; wb_addr = 5'(wa); wb_data = d;
    rs1_addr = 5'(a1); rs2_addr = 5'(a2); rs1_used = u1; rs2_used = u2;
    issue_valid = iv; issue_we = iwe; issue_rd = 5'(ird);
  endtask

  task automatic step();
    bit sat;
    bit stall;
    bit acc;
    #1;
    sat = issue_we && issue_rd != 0 && m_pend[issue_rd] == 3 && released(issue_rd) == 0;
    stall = issue_valid && (busy(rs1_used, rs1_addr) || busy(rs2_used, rs2_addr) || sat);
    acc = issue_valid && !stall;
    check("rs1_data", rs1_data, read_model(rs1_addr));
    check("rs2_data", rs2_data, read_model(rs2_addr));
    check("issue_stall", issue_stall, stall);
    check("issue_accept", issue_accept, acc);
    o_rs1 = rs1_data; o_stall = issue_stall; o_accept = issue_accept;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) begin m_reg[i] = 0; m_pend[i] = 0; end
    end else begin
      for (int i = 1; i < 32; i++) begin
        m_pend[i] = m_pend[i] + ((acc && issue_we && issue_rd == i) ? 1 : 0) - released(i);
        if (m_pend[i] < 0) m_pend[i] = 0;
      end
      if (wb_en && wb_addr != 0) m_reg[wb_addr] = wb_data;
    end
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    for (int i = 0; i < 32; i++) begin m_reg[i] = 0; m_pend[i] = 0; end
    drive(0, 0, 0, 0, 5, 31, 1, 1, 1, 0, 0); step();
    check("reset_read", o_rs1, 0);
    check("reset_stall", o_stall, 0);
    drive(0, 1, 3, 32'hDEADBEEF, 3, 0, 1, 0, 0, 0, 0); step();
    check("bypass", o_rs1, 32'hDEADBEEF);
    drive(0, 0, 3, 0, 3, 0, 1, 0, 0, 0, 0); step();
    check("committed", o_rs1, 32'hDEADBEEF);
    drive(0, 1, 0, 32'h12345678, 0, 0, 1, 1, 0, 0, 0); step();
    check("x0_bypass", o_rs1, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0); step();
    check("x0_after", o_rs1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 5); step();
    check("raw_issue", o_accept, 1);
    drive(0, 0, 0, 0, 5, 0, 1, 0, 1, 0, 0); step();
    check("raw_stall", o_stall, 1);
    drive(0, 1, 5, 32'h42, 5, 0, 1, 0, 1, 0, 0); step();
    check("raw_release", o_stall, 0);
    check("raw_data", o_rs1, 32'h42);
    check("raw_accept", o_accept, 1);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 7); step();
      check("sat_fill", o_accept, 1);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 7); step();
    check("sat_stall", o_stall, 1);
    drive(0, 1, 7, 32'h77, 0, 0, 0, 0, 1, 1, 7); step();
    check("sat_release", o_accept, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 7); step();
    check("sat_still3", o_stall, 1);
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 7, 32'h70 + k, 0, 0, 0, 0, 0, 0, 0); step();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 9); step();
    check("sim_pre", o_accept, 1);
    drive(0, 1, 9, 32'h99, 0, 0, 0, 0, 1, 1, 9); step();
    check("sim_accept", o_accept, 1);
    drive(0, 0, 0, 0, 9, 0, 1, 0, 1, 0, 0); step();
    check("sim_stall", o_stall, 1);
    drive(0, 1, 9, 32'h9A, 9, 0, 1, 0, 1, 0, 0); step();
    check("sim_clear", o_stall, 0);
    check("sim_data", o_rs1, 32'h9A);
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 9), $urandom,
            $urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 9),
            $urandom_range(0, 9), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 9));
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
